// File: rtl/init_pkg.sv
// init_pkg: shared state encoding, defaults and counter-width helper for init_seq.
package init_pkg;
  typedef enum logic [1:0] {HOLD, WAIT, STAGE, DONE} state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DELAY = 16;
  localparam int DEF_STEP = 8;
  localparam int DEF_NCH = 4;
  function automatic int cnt_w(input int delay, input int step);
    int m;
    m = delay > step ? delay : step;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: async-assert / sync-deassert reset synchroniser of STAGES flops.
module rst_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync,
  output logic rst_sync_nxt
);
  logic [STAGES-1:0] sync_q, sync_d;
  if (STAGES < 2) begin : g_chk
    $error("rst_sync_chain: STAGES must be >= 2");
  end
  always_comb sync_d = {sync_q[STAGES-2:0], 1'b0};
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '1;
    else sync_q <= sync_d;
  assign rst_sync = sync_q[STAGES-1];
  // lets the sequencer leave HOLD on the very edge rst_sync falls
  assign rst_sync_nxt = sync_d[STAGES-1];
endmodule

// File: rtl/init_seq.sv
// init_seq: power-up sequencer raising NCH thermometer init enables after a hold-off.
module init_seq
  import init_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DELAY = DEF_DELAY,
  parameter int STEP = DEF_STEP,
  parameter int NCH = DEF_NCH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           restart,
  output logic [NCH-1:0] ini,
  output logic           done,
  output logic           busy,
  output logic           rst_sync
);
  localparam int CW = cnt_w(DELAY, STEP);
  localparam logic [CW-1:0] DLY_LD = CW'(DELAY - 1);
  localparam logic [CW-1:0] STP_LD = CW'(STEP - 1);
  if (DELAY < 1 || STEP < 1 || NCH < 1 || SYNC_STAGES < 2) begin : g_chk
    $error("init_seq: illegal parameters");
  end
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0] ini_q, ini_d, ini_nxt;
  logic done_q, done_d, busy_q, busy_d, rs_nxt;
  rst_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .rst_sync(rst_sync),
    .rst_sync_nxt(rs_nxt)
  );
  always_comb begin
    ini_nxt = (ini_q << 1) | NCH'(1);
    state_d = state_q;
    cnt_d = cnt_q;
    ini_d = ini_q;
    done_d = done_q;
    if (restart && state_q != HOLD) begin
      state_d = WAIT;
      cnt_d = DLY_LD;
      ini_d = '0;
      done_d = 1'b0;
    end else if (state_q == HOLD) begin
      state_d = rs_nxt ? HOLD : WAIT;
      cnt_d = rs_nxt ? cnt_q : DLY_LD;
    end else if (state_q != DONE) begin
      if (cnt_q == '0) begin
        ini_d = ini_nxt;
        done_d = ini_nxt[NCH-1];
        state_d = ini_nxt[NCH-1] ? DONE : STAGE;
        cnt_d = STP_LD;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    busy_d = state_d == WAIT || state_d == STAGE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= HOLD;
      cnt_q <= '0;
      ini_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ini_q <= ini_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  assign ini = ini_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule
